conv_ddr_packer: RTL and testbench

- Sits directly downstream of the conv datapath output (Conv_data_out / Conv_data_valid_out, 18 ch x 8 bit = 144 bit).
- Repacks the 144-bit conv result words into dense 256-bit DDR write words.
- Buffers packed words in a small FIFO behind a valid/ready handshake, so the DDR writer can stall without stalling the conv datapath.
- Drops data and flags overflow when the FIFO is exhausted.

---
 rtl/conv_ddr_packer_pkg.sv | 8 +
 rtl/conv_ddr_packer_fifo.sv | 44 ++++
 rtl/conv_ddr_packer.sv | 109 ++++++++++
 tb/tb_conv_ddr_packer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/conv_ddr_packer_pkg.sv
// Shared constants for the conv-output -> DDR-word gearbox.
package conv_pack_defs;
    localparam int IN_WIDTH      = 144;  // 18 channels x 8 bit
    localparam int OUT_WIDTH     = 256;  // DDR word
    localparam int FILL_STEP     = 16;   // fill always moves in 16-bit steps
    localparam int IN_PER_GROUP  = 16;   // 16 conv words ...
    localparam int OUT_PER_GROUP = 9;    // ... pack into exactly 9 DDR words
endpackage

// File: rtl/conv_ddr_packer_fifo.sv
// First-word-fall-through FIFO for packed DDR words.
// A push while full is accepted only if a pop frees the head slot in the same cycle.
module packer_fifo #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, rd_q;
    logic             push_ok, pop_ok;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);
    assign data_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

    // Storage write; contents are don't-care while the slot is not live.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q[AW-1:0]] <= data_i;
    end

    // Read/write pointers with wrap bit for full/empty detection.
    always_ff @(posedge clk) begin
        if (!rstn || clr_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_ok) wr_q <= wr_q + 1'b1;
            if (pop_ok)  rd_q <= rd_q + 1'b1;
        end
    end
endmodule

// File: rtl/conv_ddr_packer.sv
// Gearbox from 144-bit conv result words to dense 256-bit DDR words,
// with flush of the partial word and an FWFT output FIFO.
module conv_ddr_packer #(
    parameter int IN_WIDTH   = conv_pack_defs::IN_WIDTH,
    parameter int OUT_WIDTH  = conv_pack_defs::OUT_WIDTH,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 state_rst,
    input  logic [IN_WIDTH-1:0]  conv_data_in,
    input  logic                 conv_valid_in,
    input  logic                 flush_in,
    output logic [OUT_WIDTH-1:0] ddr_data_out,
    output logic                 ddr_valid_out,
    input  logic                 ddr_ready_in,
    output logic                 flush_done,
    output logic                 overflow,
    output logic [CNT_WIDTH-1:0] word_cnt
);
    import conv_pack_defs::*;

    // Worst case residue (240 bits) plus one full input word fits here.
    localparam int ACC_W  = OUT_WIDTH + IN_WIDTH - FILL_STEP;
    localparam int FILL_W = $clog2(ACC_W + 1);

    logic [ACC_W-1:0]     acc_q, acc_d, comb;
    logic [FILL_W-1:0]    fill_q, fill_d, nf;
    logic                 pend_q, pend_d;
    logic                 fd_q, fd_d;
    logic                 ovf_q, ovf_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 push, pop, full, empty;
    logic [OUT_WIDTH-1:0] push_data;

    assign ddr_valid_out = ~empty;
    assign pop           = ddr_valid_out & ddr_ready_in;
    assign flush_done    = fd_q;
    assign overflow      = ovf_q;
    assign word_cnt      = cnt_q;

    // Packing, flush execution and counter next-state.
    always_comb begin
        comb      = acc_q | (ACC_W'(conv_data_in) << fill_q);
        nf        = fill_q + FILL_W'(IN_WIDTH);
        acc_d     = acc_q;
        fill_d    = fill_q;
        pend_d    = pend_q | flush_in;
        fd_d      = 1'b0;
        push      = 1'b0;
        push_data = comb[OUT_WIDTH-1:0];
        if (conv_valid_in) begin
            // Data always wins; a pending flush waits for an idle cycle.
            if (nf >= FILL_W'(OUT_WIDTH)) begin
                push   = 1'b1;
                acc_d  = comb >> OUT_WIDTH;
                fill_d = nf - FILL_W'(OUT_WIDTH);
            end else begin
                acc_d  = comb;
                fill_d = nf;
            end
        end else if (pend_q) begin
            // Bits above fill are always zero, so acc is already padded.
            pend_d    = 1'b0;
            fd_d      = 1'b1;
            push      = (fill_q != '0);
            push_data = acc_q[OUT_WIDTH-1:0];
            acc_d     = '0;
            fill_d    = '0;
        end
        ovf_d = ovf_q | (push & full & ~pop);
        cnt_d = cnt_q + CNT_WIDTH'(pop);
    end

    // Packer state registers; state_rst clears like reset.
    always_ff @(posedge clk) begin
        if (!rstn || state_rst) begin
            acc_q  <= '0;
            fill_q <= '0;
            pend_q <= 1'b0;
            fd_q   <= 1'b0;
            ovf_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            acc_q  <= acc_d;
            fill_q <= fill_d;
            pend_q <= pend_d;
            fd_q   <= fd_d;
            ovf_q  <= ovf_d;
            cnt_q  <= cnt_d;
        end
    end

    packer_fifo #(
        .WIDTH (OUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .clr_i   (state_rst),
        .push_i  (push),
        .data_i  (push_data),
        .pop_i   (pop),
        .data_o  (ddr_data_out),
        .full_o  (full),
        .empty_o (empty)
    );
endmodule

// File: tb/tb_conv_ddr_packer.sv
// Directed bench for conv_ddr_packer.
module tb_conv_ddr_packer;
    logic         clk = 1'b0;
    logic         rstn, state_rst, conv_valid_in, flush_in, ddr_ready_in;
    logic [143:0] conv_data_in;
    logic [255:0] ddr_data_out;
    logic         ddr_valid_out, flush_done, overflow;
    logic [15:0]  word_cnt;

    int           tests = 0;
    int           fails = 0;
    int           fd_cnt = 0;
    logic [255:0] q[$];
    logic [4607:0] stream;

    conv_ddr_packer dut (
        .clk           (clk),
        .rstn          (rstn),
        .state_rst     (state_rst),
        .conv_data_in  (conv_data_in),
        .conv_valid_in (conv_valid_in),
        .flush_in      (flush_in),
        .ddr_data_out  (ddr_data_out),
        .ddr_valid_out (ddr_valid_out),
        .ddr_ready_in  (ddr_ready_in),
        .flush_done    (flush_done),
        .overflow      (overflow),
        .word_cnt      (word_cnt)
    );

    always #5 clk = ~clk;

    // Capture accepted words and flush_done pulses mid-cycle.
    always @(negedge clk) begin
        if (ddr_valid_out && ddr_ready_in) q.push_back(ddr_data_out);
        if (flush_done) fd_cnt++;
    end

    function automatic logic [143:0] inw(input int k);
        logic [7:0] b;
        b = 8'(k + 1);
        return {18{b}};
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [143:0] d);
        conv_data_in  = d;
        conv_valid_in = 1'b1;
        step();
        conv_valid_in = 1'b0;
    endtask

    task automatic wait_fd(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (flush_done) begin
                seen = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        logic [143:0] a, b, in0, in1, in15;
        logic [255:0] w, w0exp;
        bit seen;
        int n;

        rstn = 1'b0; state_rst = 1'b0; conv_valid_in = 1'b0; flush_in = 1'b0;
        ddr_ready_in = 1'b0; conv_data_in = '0;
        for (int k = 0; k < 32; k++) stream[144*k +: 144] = inw(k);
        in0 = inw(0); in1 = inw(1); in15 = inw(15);
        w0exp = {in1[111:0], in0};

        // Reset state
        repeat (3) step();
        chk("rst_valid", ddr_valid_out, 0);
        chk("rst_data", ddr_data_out, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_cnt", word_cnt, 0);
        chk("rst_fd", flush_done, 0);
        rstn = 1'b1;
        step();

        // T1: full 16-word group with ready high
        ddr_ready_in = 1'b1;
        q.delete();
        for (int k = 0; k < 16; k++) send(inw(k));
        repeat (4) step();
        chk("t1_nwords", q.size(), 9);
        if (q.size() == 9) begin
            for (int j = 0; j < 9; j++)
                chk($sformatf("t1_word%0d", j), q[j], stream[256*j +: 256]);
            chk("t1_w0_concat", q[0], w0exp);
            w = q[8];
            chk("t1_w8_upper", w[255:112], in15);
        end
        chk("t1_cnt", word_cnt, 9);
        chk("t1_valid", ddr_valid_out, 0);

        // T3: flush with fill back at 0 -> no word, single flush_done
        n = fd_cnt;
        flush_in = 1'b1; step(); flush_in = 1'b0;
        wait_fd(seen);
        chk("t3_fd_seen", seen, 1);
        chk("t3_no_word", ddr_valid_out, 0);
        step();
        chk("t3_fd_low", flush_done, 0);
        repeat (2) step();
        chk("t3_fd_once", fd_cnt, n + 1);
        chk("t3_nwords", q.size(), 9);
        chk("t3_cnt", word_cnt, 9);

        // T2: one word then flush -> zero-padded word
        q.delete();
        a = inw(40);
        n = fd_cnt;
        send(a);
        flush_in = 1'b1; step(); flush_in = 1'b0;
        wait_fd(seen);
        chk("t2_fd_seen", seen, 1);
        chk("t2_valid_with_fd", ddr_valid_out, 1);
        chk("t2_data", ddr_data_out, {112'b0, a});
        step();
        chk("t2_fd_low", flush_done, 0);
        repeat (2) step();
        chk("t2_fd_once", fd_cnt, n + 1);
        chk("t2_nwords", q.size(), 1);
        if (q.size() == 1) chk("t2_qword", q[0], {112'b0, a});
        chk("t2_cnt", word_cnt, 10);

        // T5: data and flush in the same cycle
        q.delete();
        b = inw(60);
        conv_data_in = b; conv_valid_in = 1'b1; flush_in = 1'b1;
        step();
        conv_valid_in = 1'b0; flush_in = 1'b0;
        chk("t5_no_early_fd", flush_done, 0);
        chk("t5_no_early_word", ddr_valid_out, 0);
        wait_fd(seen);
        chk("t5_fd_seen", seen, 1);
        chk("t5_data", ddr_data_out, {112'b0, b});
        repeat (3) step();
        chk("t5_nwords", q.size(), 1);
        chk("t5_cnt", word_cnt, 11);

        // T4: overflow with ready low, then drain
        state_rst = 1'b1; step(); state_rst = 1'b0;
        chk("t4_cnt_clr", word_cnt, 0);
        ddr_ready_in = 1'b0;
        q.delete();
        for (int k = 0; k < 32; k++) send(inw(k));
        step();
        chk("t4_ovf", overflow, 1);
        chk("t4_valid", ddr_valid_out, 1);
        chk("t4_head", ddr_data_out, stream[255:0]);
        ddr_ready_in = 1'b1;
        repeat (12) step();
        ddr_ready_in = 1'b0;
        chk("t4_nwords", q.size(), 8);
        if (q.size() == 8) begin
            for (int j = 0; j < 8; j++)
                chk($sformatf("t4_word%0d", j), q[j], stream[256*j +: 256]);
        end
        chk("t4_cnt", word_cnt, 8);
        chk("t4_ovf_sticky", overflow, 1);
        chk("t4_empty", ddr_valid_out, 0);

        // T6: state_rst mid-stream (fill=32, 3 words held)
        send(inw(70)); flush_in = 1'b1; step(); flush_in = 1'b0;
        wait_fd(seen);
        chk("t6_fd1", seen, 1);
        send(inw(71)); flush_in = 1'b1; step(); flush_in = 1'b0;
        wait_fd(seen);
        chk("t6_fd2", seen, 1);
        send(inw(0));
        send(inw(1));
        step();
        chk("t6_pre_valid", ddr_valid_out, 1);
        chk("t6_pre_ovf", overflow, 1);
        state_rst = 1'b1; step(); state_rst = 1'b0;
        chk("t6_valid", ddr_valid_out, 0);
        chk("t6_data", ddr_data_out, 0);
        chk("t6_cnt", word_cnt, 0);
        chk("t6_ovf", overflow, 0);
        ddr_ready_in = 1'b1;
        q.delete();
        for (int k = 0; k < 16; k++) send(inw(k));
        repeat (4) step();
        chk("t6_nwords", q.size(), 9);
        if (q.size() == 9) begin
            for (int j = 0; j < 9; j++)
                chk($sformatf("t6_word%0d", j), q[j], stream[256*j +: 256]);
        end
        chk("t6_cnt9", word_cnt, 9);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
